wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Writer side of the register file's single write port. Merges in-order pipeline writeback (source A, never stalled) with results from the multicycle multiply/divide unit (source B, valid/ready) into one registered `regWrite`/`write_reg`/`write_data_reg` stream. Buffers B results, kills stale B results overwritten by younger A writes (WAW), and exports a pending-register mask for decode interlock. Sits between the writeback stage / mul-div unit and the register file.

## Interface
- `DEPTH`, 4: B result buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 8: cycles a live buffer head may wait before `stall_req` asserts.
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a_valid` input 1: pipeline writeback request this cycle.
- `a_reg` input 5: destination register for A.
- `a_data` input 32: write data for A.
- `b_valid` input 1: mul/div result offered.
- `b_ready` output 1: buffer can accept; `!rst && !full`.
- `b_reg` input 5: destination register for B.
- `b_data` input 32: write data for B.
- `regWrite` output 1: registered write enable to register file.
- `write_reg` output 5: registered write address.
- `write_data_reg` output 32: registered write data.
- `pend_mask` output 32: bit r set when a write to r is buffered or in the output register.
- `stall_req` output 1: asks the pipeline to withhold `a_valid` so the buffer can drain.

## Operation
- Buffer: circular FIFO of `DEPTH` entries {live, reg, data}; B accepted on `b_valid && b_ready`.
- Per-cycle selection, in priority order:
  - `a_valid`: output register loads A.
  - Else, live head: output register loads head, pop.
  - Else: output register loads `regWrite`=0.
- Dead head entries are popped with no write, one per cycle, regardless of `a_valid`.
- Writes to register 0 are consumed but produce `regWrite`=0. Entries with reg 0 are enqueued dead.
- WAW kill: when `a_valid` and `a_reg`≠0, every live entry with reg == `a_reg` is marked dead this edge. A B result accepted in the same cycle with `b_reg` == `a_reg` is enqueued dead, since B is older.
- Simultaneous accept and pop in one cycle is legal at any occupancy, including full. `b_ready` still reflects the pre-pop full state.
- `pend_mask`: OR over live entries of (1<<reg), plus (1<<`write_reg`) when `regWrite`. Bit 0 is always 0. Combinational from state.
- Starvation: `head_age` counter increments each cycle the head is live and not popped, and clears on pop or when the head is dead. `stall_req` is asserted while `head_age` ≥ `STARVE_LIMIT`. If `a_valid` arrives anyway, A still wins and the counter keeps counting (saturates).

## Timing
- Reset (sync): FIFO empty, pointers and `head_age` 0. Outputs `regWrite`=0, `write_reg`=0, `write_data_reg`=0, `pend_mask`=0, `stall_req`=0, `b_ready`=0 while `rst` is high.
- A presented in cycle N: output valid in N+1; register file updated at the end of N+1.
- B accepted in cycle N, buffer otherwise empty, no A: output valid in N+2.
- Full: `b_ready`=0 in the same cycle. It rises the cycle after a pop.
- Pointer wrap: modulo `DEPTH`. Full/empty are distinguished by an extra pointer bit.
- Reset asserted mid-stream discards all buffered entries and the pending output. No write is emitted in the cycle after reset.

## Configuration
- `WB_WRITE_TRACE_EN`: when defined, each cycle the output register loads a write with reg≠0, `$display("WB %s r%0d <= %h", src, reg, data)` is printed, with src "A" or "B". Killed and dead entries are printed as "WB kill r%0d".
- When undefined, there is no simulation output. Logic is identical in both cases.

## Test plan
- A only: `a_valid`=1, `a_reg`=5, `a_data`=32'hDEADBEEF in cycle N → `regWrite`=1, `write_reg`=5, data DEADBEEF in N+1. `pend_mask`[5]=1 in N+1 only.
- B only with continuous `a_valid`: accept `b_reg`=7, data 32'h12345678, then hold `a_valid`=1 with `a_reg`=3 → `stall_req`=1 after 8 waiting cycles. Drop `a_valid` → B write r7 on the next cycle and `stall_req`=0.
- WAW kill: buffer holds r9=32'h1, then A writes r9=32'h2 → only the A write (32'h2) reaches the output. The r9 entry is popped dead and `pend_mask`[9] clears.
- Same-cycle conflict: `a_valid` r4=32'hA and `b_valid` r4=32'hB together → r4 gets 32'hA only; the B entry is dead.
- Fill and wrap: enqueue 4 B results with `a_valid` held high → `b_ready`=0. Release → 4 writes in FIFO order on consecutive cycles. Then 6 more with interleaved A; order is preserved across wrap.
- Reg 0 and reset: A write to r0 → `regWrite` stays 0. Assert `rst` with 3 entries buffered → empty, all outputs 0, and no stale write after release.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// Bundle of the writeback-source, mul/div-source and register-file-write signals
// handled by wb_write_arbiter. The arbiter uses the slave modport.
interface wb_write_arbiter_if;
   // Source B transfers on a rising edge where b_valid && b_ready; b_data/b_reg
   // must hold while b_valid is high and b_ready low. Source A has no ready.
   logic        a_valid;
   logic [4:0]  a_reg;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_reg;
   logic [31:0] b_data;
   logic        regWrite;
   logic [4:0]  write_reg;
   logic [31:0] write_data_reg;
   logic [31:0] pend_mask;
   logic        stall_req;

   modport slave (
      input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      output b_ready, regWrite, write_reg, write_data_reg, pend_mask, stall_req
   );

   modport master (
      output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      input  b_ready, regWrite, write_reg, write_data_reg, pend_mask, stall_req
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: A (writeback) always wins, B (mul/div) is buffered.
// Optional trace printing is enabled by defining WB_WRITE_TRACE_EN.
module wb_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic              clk,
   input logic              rst,
   wb_write_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW:0]   PTR_ONE = 1;
   localparam logic [HW-1:0] AGE_ONE = 1;
   localparam logic [HW-1:0] AGE_LIM = HW'(STARVE_LIMIT);

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [AW-1:0]    wr_idx, rd_idx;
   logic [DEPTH-1:0] live;
   logic [4:0]       ent_reg  [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   logic [HW-1:0]    head_age;
   logic             wr_en_q;
   logic [4:0]       wr_reg_q;
   logic [31:0]      wr_data_q;

   logic empty, full, head_live, head_dead, accept, pop, a_kill, enq_live;
   logic [31:0] pend;

   assign wr_idx    = wr_ptr[AW-1:0];
   assign rd_idx    = rd_ptr[AW-1:0];
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
   assign head_live = !empty && live[rd_idx];
   assign head_dead = !empty && !live[rd_idx];
   assign accept    = bus.b_valid && bus.b_ready;
   // A dead head drains even under A traffic; a live head only when A is idle.
   assign pop       = head_dead || (head_live && !bus.a_valid);
   assign a_kill    = bus.a_valid && (bus.a_reg != 5'd0);
   // B is older than a same-cycle A to the same register, so it is born dead.
   assign enq_live  = (bus.b_reg != 5'd0) && !(bus.a_valid && (bus.a_reg == bus.b_reg));

   always_ff @(posedge clk) begin
      if (accept) begin
         ent_reg[wr_idx]  <= bus.b_reg;
         ent_data[wr_idx] <= bus.b_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         live      <= '0;
         head_age  <= '0;
         wr_en_q   <= 1'b0;
         wr_reg_q  <= 5'd0;
         wr_data_q <= 32'd0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (a_kill && live[i] && (ent_reg[i] == bus.a_reg)) live[i] <= 1'b0;
         end
         // Popped slots are cleared so live[] alone describes occupancy for pend_mask.
         if (pop) begin
            live[rd_idx] <= 1'b0;
            rd_ptr       <= rd_ptr + PTR_ONE;
         end
         if (accept) begin
            live[wr_idx] <= enq_live;
            wr_ptr       <= wr_ptr + PTR_ONE;
         end

         if (bus.a_valid) begin
            wr_en_q   <= (bus.a_reg != 5'd0);
            wr_reg_q  <= bus.a_reg;
            wr_data_q <= bus.a_data;
         end else if (head_live) begin
            wr_en_q   <= 1'b1;
            wr_reg_q  <= ent_reg[rd_idx];
            wr_data_q <= ent_data[rd_idx];
         end else begin
            wr_en_q   <= 1'b0;
         end

         if (head_live && !pop) begin
            if (head_age != AGE_LIM) head_age <= head_age + AGE_ONE;
         end else begin
            head_age <= '0;
         end
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i]) pend[ent_reg[i]] = 1'b1;
      end
      if (wr_en_q) pend[wr_reg_q] = 1'b1;
      pend[0] = 1'b0;
   end

   // Outputs are forced quiet for the whole time rst is held.
   assign bus.b_ready        = !rst && !full;
   assign bus.regWrite       = !rst && wr_en_q;
   assign bus.write_reg      = rst ? 5'd0  : wr_reg_q;
   assign bus.write_data_reg = rst ? 32'd0 : wr_data_q;
   assign bus.pend_mask      = rst ? 32'd0 : pend;
   assign bus.stall_req      = !rst && (head_age >= AGE_LIM);

`ifdef WB_WRITE_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (a_kill)
            $display("WB %s r%0d <= %h", "A", bus.a_reg, bus.a_data);
         else if (!bus.a_valid && head_live)
            $display("WB %s r%0d <= %h", "B", ent_reg[rd_idx], ent_data[rd_idx]);
         if (head_dead)
            $display("WB kill r%0d", ent_reg[rd_idx]);
      end
   end
`else
   // Trace disabled: no simulation output.
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected writes are queued at stimulus time,
// a negedge monitor compares every regWrite against the queue head.
module tb_wb_write_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   logic [36:0] exp_q[$];
   logic [36:0] mon_exp;

   wb_write_arbiter_if bus ();

   wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
      bus.a_valid = av;
      bus.a_reg   = ar;
      bus.a_data  = ad;
      bus.b_valid = bv;
      bus.b_reg   = br;
      bus.b_data  = bd;
   endtask

   task automatic clear_in();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic push(input logic [4:0] r, input logic [31:0] d);
      exp_q.push_back({r, d});
   endtask

   always @(negedge clk) begin
      if (!rst && bus.regWrite) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got r%0d=%h expected none", bus.write_reg,
                     bus.write_data_reg);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.write_reg, bus.write_data_reg} !== mon_exp) begin
               n_err++;
               $display("FAIL write_order: got r%0d=%h expected r%0d=%h", bus.write_reg,
                        bus.write_data_reg, mon_exp[36:32], mon_exp[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      clear_in();
      step(); step(); step();
      check("rst_b_ready",  bus.b_ready,   0);
      check("rst_regwrite", bus.regWrite,  0);
      check("rst_pend",     bus.pend_mask, 0);
      check("rst_stall",    bus.stall_req, 0);
      rst = 1'b0;
      #1;
      check("post_rst_b_ready", bus.b_ready, 1);

      // B-only latency: accepted at N, written in N+2.
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 32'h2525_2525);
      push(5'd25, 32'h2525_2525);
      step();
      clear_in();
      check("b_lat_n1", bus.regWrite, 0);
      step();
      check("b_lat_n2", bus.regWrite, 1);

      // A only.
      set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
      push(5'd5, 32'hDEAD_BEEF);
      step();
      check("a_pend", bus.pend_mask, 32'h0000_0020);
      clear_in();
      step();
      check("a_pend_clear", bus.pend_mask, 0);
      check("a_idle", bus.regWrite, 0);

      // Starvation behind continuous A.
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5678);
      step();
      for (int k = 0; k < 10; k++) begin
         set_in(1'b1, 5'd3, 32'h30 + k, 1'b0, 5'd0, 32'd0);
         push(5'd3, 32'h30 + k);
         step();
         if (k == 0) check("starve_pend", bus.pend_mask, 32'h0000_0088);
         if (k == 6) check("starve_below", bus.stall_req, 0);
         if (k == 7) check("starve_at_limit", bus.stall_req, 1);
         if (k == 9) check("starve_saturated", bus.stall_req, 1);
      end
      clear_in();
      push(5'd7, 32'h1234_5678);
      step();
      check("starve_release", bus.stall_req, 0);
      check("starve_pend_out", bus.pend_mask, 32'h0000_0080);
      step();

      // WAW kill of a buffered entry.
      set_in(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h1);
      push(5'd1, 32'h11);
      step();
      set_in(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
      push(5'd9, 32'h2);
      step();
      check("waw_pend", bus.pend_mask, 32'h0000_0200);
      clear_in();
      step();
      check("waw_pend_clear", bus.pend_mask, 0);
      check("waw_no_write", bus.regWrite, 0);

      // Same-cycle A and B to one register.
      set_in(1'b1, 5'd4, 32'hA, 1'b1, 5'd4, 32'hB);
      push(5'd4, 32'hA);
      step();
      check("same_pend", bus.pend_mask, 32'h0000_0010);
      clear_in();
      step();
      check("same_pend_clear", bus.pend_mask, 0);
      check("same_no_write", bus.regWrite, 0);

      // Fill to full behind A, then drain in order.
      for (int i = 0; i < 4; i++) begin
         check("fill_ready", bus.b_ready, 1);
         set_in(1'b1, 5'd2, 32'h200 + i, 1'b1, 5'(10 + i), 32'hB0 + i);
         push(5'd2, 32'h200 + i);
         step();
      end
      check("full_not_ready", bus.b_ready, 0);
      set_in(1'b1, 5'd2, 32'h204, 1'b1, 5'd14, 32'hBE);
      push(5'd2, 32'h204);
      step();
      check("full_still", bus.b_ready, 0);
      check("full_pend", bus.pend_mask, 32'h0000_3C04);
      clear_in();
      for (int i = 0; i < 4; i++) push(5'(10 + i), 32'hB0 + i);
      step();
      check("drain_ready", bus.b_ready, 1);
      step(); step(); step(); step();

      // Wrap with interleaved A.
      for (int i = 0; i < 6; i++) begin
         check("wrap_ready", bus.b_ready, 1);
         if (i % 2 == 0) begin
            set_in(1'b1, 5'd1, 32'hA0 + i, 1'b1, 5'(16 + i), 32'hC0 + i);
            push(5'd1, 32'hA0 + i);
         end else begin
            set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + i), 32'hC0 + i);
            push(5'(16 + (i - 1) / 2), 32'hC0 + (i - 1) / 2);
         end
         step();
      end
      clear_in();
      push(5'd19, 32'hC3);
      push(5'd20, 32'hC4);
      push(5'd21, 32'hC5);
      step(); step(); step(); step();

      // Register 0 from both sources.
      set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h5);
      step();
      check("r0_no_write", bus.regWrite, 0);
      check("r0_pend", bus.pend_mask, 0);
      clear_in();
      step();
      check("r0_dead_pop", bus.regWrite, 0);

      // Reset with three entries buffered and a write pending.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 5'd2, 32'h300 + i, 1'b1, 5'(20 + i), 32'hD0 + i);
         if (i < 2) push(5'd2, 32'h300 + i);
         step();
      end
      check("mid_pend", bus.pend_mask, 32'h0070_0004);
      rst = 1'b1;
      clear_in();
      #1;
      check("mid_rst_regwrite", bus.regWrite, 0);
      check("mid_rst_pend", bus.pend_mask, 0);
      check("mid_rst_b_ready", bus.b_ready, 0);
      step(); step();
      check("mid_rst_stall", bus.stall_req, 0);
      rst = 1'b0;
      step();
      check("post_mid_regwrite", bus.regWrite, 0);
      check("post_mid_pend", bus.pend_mask, 0);
      check("post_mid_ready", bus.b_ready, 1);
      step(); step(); step();
      check("post_mid_quiet", bus.regWrite, 0);

      check("exp_q_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
